// File: rtl/i_mem_loader.sv
// Boot loader owning the i_mem port: a 4-byte LE word count, then LE payload words written from BASE_ADDR while the core stalls.
// Min 5 cycles/word (4 bytes + 1 write), rx_ready low during WRITE; I_MEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
module i_mem_loader #(
  parameter int unsigned          BUS_WIDTH = 32,
  parameter logic [BUS_WIDTH-1:0] BASE_ADDR = '0,
  parameter int unsigned          MAX_WORDS = 1024,
  parameter int unsigned          CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic                 rx_ready,
  input  logic [BUS_WIDTH-1:0] pc,
  output logic [BUS_WIDTH-1:0] i_mem_address,
  output logic                 i_mem_wr_en,
  output logic [BUS_WIDTH-1:0] i_mem_wr_data,
  output logic                 cpu_stall,
  output logic                 load_done,
  output logic                 load_err,
  output logic [CNT_WIDTH-1:0] words_loaded
);

`ifdef I_MEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_WRITE, S_DONE, S_ERR, S_CHK} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_WRITE, S_DONE, S_ERR} state_t;
`endif

  state_t                 r_state;
  logic                   r_rx_ready;
  logic                   r_wr_en;
  logic [BUS_WIDTH-1:0]   r_wr_data;
  logic                   r_stall;
  logic                   r_done;
  logic                   r_err;
  logic [CNT_WIDTH-1:0]   r_word_idx;
  logic [1:0]             r_byte_cnt;
  logic [31:0]            r_len;
  logic [31:0]            r_word;
`ifdef I_MEM_LOADER_CHECKSUM_EN
  logic [7:0]             r_chk;
`endif

  logic                   w_hs;
  logic                   w_byte3;
  logic                   w_last;
  logic [31:0]            w_len_next;
  logic [31:0]            w_word_next;
  logic [BUS_WIDTH-1:0]   w_word_addr;

  assign w_hs        = rx_valid & r_rx_ready;
  assign w_byte3     = (r_byte_cnt == 2'd3);
  assign w_len_next  = {rx_data, r_len[31:8]};
  assign w_word_next = {rx_data, r_word[31:8]};
  assign w_last      = ((32'(r_word_idx) + 32'd1) == r_len);
  assign w_word_addr = BASE_ADDR + (BUS_WIDTH'(r_word_idx) << 2);

  // Only IDLE and DONE hand the port back to the core's fetch path.
  assign i_mem_address = (r_state == S_IDLE || r_state == S_DONE) ? pc : w_word_addr;
  assign rx_ready      = r_rx_ready;
  assign i_mem_wr_en   = r_wr_en;
  assign i_mem_wr_data = r_wr_data;
  assign cpu_stall     = r_stall;
  assign load_done     = r_done;
  assign load_err      = r_err;
  assign words_loaded  = r_word_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_rx_ready <= 1'b0;
      r_wr_en    <= 1'b0;
      r_wr_data  <= '0;
      r_stall    <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_word_idx <= '0;
      r_byte_cnt <= '0;
      r_len      <= '0;
      r_word     <= '0;
`ifdef I_MEM_LOADER_CHECKSUM_EN
      r_chk      <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            r_state    <= S_LEN;
            r_rx_ready <= 1'b1;
            r_stall    <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_word_idx <= '0;
            r_byte_cnt <= '0;
            r_len      <= '0;
`ifdef I_MEM_LOADER_CHECKSUM_EN
            r_chk      <= '0;
`endif
          end
        end
        S_LEN: begin
          if (w_hs) begin
            r_len      <= w_len_next;
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (w_byte3) begin
              if (w_len_next == '0) begin
`ifdef I_MEM_LOADER_CHECKSUM_EN
                r_state    <= S_CHK;
`else
                r_state    <= S_DONE;
                r_rx_ready <= 1'b0;
                r_stall    <= 1'b0;
                r_done     <= 1'b1;
`endif
              end else if (w_len_next > MAX_WORDS) begin
                r_state    <= S_ERR;
                r_rx_ready <= 1'b0;
                r_err      <= 1'b1;
              end else begin
                r_state    <= S_DATA;
              end
            end
          end
        end
        S_DATA: begin
          if (w_hs) begin
            r_word     <= w_word_next;
            r_byte_cnt <= r_byte_cnt + 2'd1;
`ifdef I_MEM_LOADER_CHECKSUM_EN
            r_chk      <= r_chk ^ rx_data;
`endif
            if (w_byte3) begin
              r_state    <= S_WRITE;
              r_rx_ready <= 1'b0;
              r_wr_en    <= 1'b1;
              r_wr_data  <= BUS_WIDTH'(w_word_next);
            end
          end
        end
        S_WRITE: begin
          r_wr_en    <= 1'b0;
          r_word_idx <= r_word_idx + CNT_WIDTH'(1);
          if (w_last) begin
`ifdef I_MEM_LOADER_CHECKSUM_EN
            r_state    <= S_CHK;
            r_rx_ready <= 1'b1;
`else
            r_state    <= S_DONE;
            r_stall    <= 1'b0;
            r_done     <= 1'b1;
`endif
          end else begin
            r_state    <= S_DATA;
            r_rx_ready <= 1'b1;
          end
        end
`ifdef I_MEM_LOADER_CHECKSUM_EN
        S_CHK: begin
          if (w_hs) begin
            r_rx_ready <= 1'b0;
            if (rx_data == r_chk) begin
              r_state <= S_DONE;
              r_stall <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
            end
          end
        end
`endif
        default: begin
          r_state    <= S_IDLE;
          r_rx_ready <= 1'b0;
          r_wr_en    <= 1'b0;
          r_stall    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i_mem_loader.sv
// Bench for i_mem_loader: randomized byte streams against a queue-based write model plus literal pinned loads.
// Honours I_MEM_LOADER_CHECKSUM_EN by appending the XOR checksum byte to each session.
module tb_i_mem_loader;
  localparam int unsigned BW   = 32;
  localparam int unsigned CW   = 16;
  localparam int unsigned MAXW = 16;
  localparam logic [BW-1:0] BASE = 32'h0000_0100;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  logic [BW-1:0] pc = '0;
  logic [BW-1:0] i_mem_address;
  logic          i_mem_wr_en;
  logic [BW-1:0] i_mem_wr_data;
  logic          cpu_stall;
  logic          load_done;
  logic          load_err;
  logic [CW-1:0] words_loaded;

  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;
  int wr_cnt = 0;
  bit mon_on = 1'b0;
  bit prev_wr = 1'b0;
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  logic [7:0]  tx_q[$];

  i_mem_loader #(
    .BUS_WIDTH(BW), .BASE_ADDR(BASE), .MAX_WORDS(MAXW), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .pc(pc), .i_mem_address(i_mem_address), .i_mem_wr_en(i_mem_wr_en),
    .i_mem_wr_data(i_mem_wr_data), .cpu_stall(cpu_stall), .load_done(load_done),
    .load_err(load_err), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Per-cycle monitor: every write must match the next expected (address, word); fetch path owns the port when not stalled.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!rst && mon_on) begin
        if (rx_valid && rx_ready) hs_cnt++;
        if (i_mem_wr_en) begin
          wr_cnt++;
          if (exp_addr_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: addr %h data %h, required no write", i_mem_address, i_mem_wr_data);
          end else begin
            check("wr_addr", i_mem_address, exp_addr_q.pop_front());
            check("wr_data", i_mem_wr_data, exp_data_q.pop_front());
          end
          check("rx_ready_in_write", 32'(rx_ready), 32'd0);
          check("stall_in_write", 32'(cpu_stall), 32'd1);
          check("wr_single_cycle", 32'(prev_wr), 32'd0);
        end
        if (!cpu_stall) check("fetch_addr", i_mem_address, pc);
        check("done_err_exclusive", 32'(load_done & load_err), 32'd0);
        prev_wr = i_mem_wr_en;
      end else begin
        prev_wr = 1'b0;
      end
    end
  end

  initial begin : pc_drv
    forever begin
      @(posedge clk);
      #1 pc = $urandom;
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Present a byte after a random idle gap and hold it until accepted; sometimes pulse start mid-session (must be ignored).
  task automatic send_byte(input logic [7:0] b);
    int gap;
    int n;
    bit acc;
    gap = $urandom_range(0, 2);
    repeat (gap) begin @(posedge clk); #1; end
    rx_data  = b;
    rx_valid = 1'b1;
    if ($urandom_range(0, 7) == 0) start = 1'b1;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 50) begin
      acc = rx_ready;
      @(posedge clk); #1;
      start = 1'b0;
      n++;
    end
    rx_valid = 1'b0;
    rx_data  = $urandom;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL rx_timeout: byte %h not accepted in 50 cycles, required acceptance", b);
    end
  endtask

  task automatic run_session(input string nm, input bit exp_err, input logic [15:0] exp_wl);
    int base_hs;
    int nb;
    int n;
    nb = tx_q.size();
    pulse_start();
    base_hs = hs_cnt;
    while (tx_q.size() > 0) send_byte(tx_q.pop_front());
    n = 0;
    while (!load_done && !load_err && n < 20) begin @(posedge clk); #1; n++; end
    check({nm, "_done"}, 32'(load_done), 32'(!exp_err));
    check({nm, "_err"}, 32'(load_err), 32'(exp_err));
    check({nm, "_stall"}, 32'(cpu_stall), 32'(exp_err));
    check({nm, "_words_loaded"}, 32'(words_loaded), 32'(exp_wl));
    check({nm, "_pending_writes"}, 32'(exp_addr_q.size()), 32'd0);
    check({nm, "_bytes_consumed"}, 32'(hs_cnt - base_hs), 32'(nb));
  endtask

  task automatic rand_session(input logic [31:0] len, input bit bad_chk);
    logic [31:0] w;
    logic [7:0]  x;
    bit          err;
    x = 8'h00;
    err = (len > MAXW);
    for (int i = 0; i < 4; i++) tx_q.push_back(len[8*i +: 8]);
    if (!err) begin
      for (int k = 0; k < int'(len); k++) begin
        w = $urandom;
        exp_addr_q.push_back(BASE + 32'(k) * 32'd4);
        exp_data_q.push_back(w);
        for (int i = 0; i < 4; i++) begin
          tx_q.push_back(w[8*i +: 8]);
          x = x ^ w[8*i +: 8];
        end
      end
`ifdef I_MEM_LOADER_CHECKSUM_EN
      tx_q.push_back(bad_chk ? ~x : x);
      err = bad_chk;
`endif
    end
    run_session(bad_chk ? "bad_chk" : "rand", err, (len > MAXW) ? 16'd0 : len[15:0]);
  endtask

  task automatic check_reset_vals(input string nm);
    check({nm, "_rx_ready"}, 32'(rx_ready), 32'd0);
    check({nm, "_wr_en"}, 32'(i_mem_wr_en), 32'd0);
    check({nm, "_wr_data"}, i_mem_wr_data, 32'd0);
    check({nm, "_stall"}, 32'(cpu_stall), 32'd0);
    check({nm, "_done"}, 32'(load_done), 32'd0);
    check({nm, "_err"}, 32'(load_err), 32'd0);
    check({nm, "_words_loaded"}, 32'(words_loaded), 32'd0);
    check({nm, "_addr_pc"}, i_mem_address, pc);
  endtask

  initial begin : main
    int base_wr;
    logic [7:0] x;
    logic [31:0] len;

    // Power-on reset with random inputs.
    rx_valid = 1'b1;
    rx_data  = $urandom;
    #2 rst = 1'b1;
    #1 check_reset_vals("por");
    repeat (2) @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rst = 1'b0;
    mon_on = 1'b1;
    @(posedge clk); #1;

    // Two-word literal load.
    tx_q = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    x = 8'h00;
    for (int i = 4; i < 12; i++) x = x ^ tx_q[i];
`ifdef I_MEM_LOADER_CHECKSUM_EN
    tx_q.push_back(x);
`endif
    exp_addr_q.push_back(32'h0000_0100); exp_data_q.push_back(32'h1234_5678);
    exp_addr_q.push_back(32'h0000_0104); exp_data_q.push_back(32'hDEAD_BEEF);
    base_wr = wr_cnt;
    run_session("two_word", 1'b0, 16'd2);
    check("two_word_write_count", 32'(wr_cnt - base_wr), 32'd2);

    // Zero length: DONE on the edge that takes the 4th length byte.
    base_wr = wr_cnt;
    pulse_start();
    for (int i = 0; i < 4; i++) send_byte(8'h00);
`ifdef I_MEM_LOADER_CHECKSUM_EN
    check("len0_chk_rx_ready", 32'(rx_ready), 32'd1);
    send_byte(8'h00);
`endif
    check("len0_done", 32'(load_done), 32'd1);
    check("len0_stall", 32'(cpu_stall), 32'd0);
    check("len0_words_loaded", 32'(words_loaded), 32'd0);
    check("len0_no_write", 32'(wr_cnt - base_wr), 32'd0);

    // Oversized length, then a valid one-word load clears the error.
    base_wr = wr_cnt;
    rand_session(MAXW + 1, 1'b0);
    check("oversize_no_write", 32'(wr_cnt - base_wr), 32'd0);
    rand_session(32'd1, 1'b0);

    // Reset after 2 payload bytes of word 0.
    base_wr = wr_cnt;
    pulse_start();
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte($urandom); send_byte($urandom);
    rx_valid = 1'b1;
    rx_data  = $urandom;
    #2 rst = 1'b1;
    start = $urandom_range(0, 1);
    #1 check_reset_vals("midrst");
    @(posedge clk); #2;
    check("midrst_addr_tracks_pc", i_mem_address, pc);
    rx_valid = 1'b0;
    start = 1'b0;
    #1 rst = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    check("midrst_no_write", 32'(wr_cnt - base_wr), 32'd0);
    check("midrst_stall", 32'(cpu_stall), 32'd0);
    check("midrst_done", 32'(load_done), 32'd0);

    // Randomized sessions.
    for (int s = 0; s < 12; s++) begin
      if ($urandom_range(0, 4) == 0) len = MAXW + 1 + $urandom_range(0, 1000);
      else len = $urandom_range(1, 6);
`ifdef I_MEM_LOADER_CHECKSUM_EN
      rand_session(len, ($urandom_range(0, 3) == 0));
`else
      rand_session(len, 1'b0);
`endif
    end
    rand_session(MAXW, 1'b0);
`ifdef I_MEM_LOADER_CHECKSUM_EN
    rand_session(32'd2, 1'b1);
`endif

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i_mem_loader.md
Name: i_mem_loader

Overview:
- Boot/program loader and access controller for the instruction memory port.
- Owns the single i_mem port and muxes between the core's fetch address and a loader write path.
- Receives a byte stream over valid/ready: a 4-byte word count, then payload bytes, packed little-endian into 32-bit words.
- Writes each word sequentially from BASE_ADDR, holding the core stalled until the load completes.

Parameters:
BUS_WIDTH, 32, address/data width of the i_mem port
BASE_ADDR, 32'h0000_0000, byte address of the first loaded word (word-aligned)
MAX_WORDS, 1024, largest accepted word count; a larger count is an error
CNT_WIDTH, 16, width of the word counter and words_loaded

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  single-cycle pulse that begins a load session
rx_data  in  8  incoming stream byte
rx_valid  in  1  rx_data is valid
rx_ready  out  1  loader accepts the byte this cycle
pc  in  BUS_WIDTH  core fetch address
i_mem_address  out  BUS_WIDTH  address to i_mem
i_mem_wr_en  out  1  i_mem write enable
i_mem_wr_data  out  BUS_WIDTH  word to write
cpu_stall  out  1  core must hold its PC and pipeline
load_done  out  1  last session completed successfully
load_err  out  1  last session aborted
words_loaded  out  CNT_WIDTH  words written in the current or last session

Behaviour:
- Byte transfer occurs on a rising edge where rx_valid and rx_ready are both 1. The source holds rx_data/rx_valid until accepted.
- State register is reset asynchronously. All outputs are decoded from registered state/datapath, so none depends combinationally on rx_valid.
- Reset values: state IDLE, rx_ready 0, i_mem_wr_en 0, i_mem_wr_data 0, cpu_stall 0, load_done 0, load_err 0, words_loaded 0. Byte counter, length and word index are all 0.
- IDLE: i_mem_address = pc, cpu_stall 0. start -> LEN; the same edge clears the counters, load_done and load_err.
- LEN: rx_ready 1, cpu_stall 1. Four bytes are accepted, LSB first, into a 32-bit length.
  - Length 0 -> DONE on the edge after the 4th byte.
  - Length > MAX_WORDS -> ERR.
  - Otherwise -> DATA.
- DATA: rx_ready 1. Four bytes are accepted LSB first into the word register. The 4th byte -> WRITE.
- WRITE: rx_ready 0 and i_mem_wr_en 1 for exactly one cycle.
  - i_mem_address = BASE_ADDR + 4*word_idx.
  - i_mem_wr_data = assembled word.
  - On the edge: word_idx increments. If word_idx+1 == length -> DONE (or CHK, see Optional Feature); else -> DATA.
- DONE: i_mem_address = pc, cpu_stall 0, load_done 1 held. start -> LEN.
- ERR: cpu_stall 1, load_err 1 held, rx_ready 0, no writes. start -> LEN. rst -> IDLE.
- Non-fetch states (LEN, DATA, WRITE, CHK, ERR):
  - i_mem_address = BASE_ADDR + 4*word_idx.
  - i_mem_wr_en is 1 only in WRITE.
- words_loaded = word_idx. Address arithmetic is modulo 2^BUS_WIDTH.
- Throughput: a minimum of 5 cycles per word (4 byte handshakes + 1 write).
- start is ignored in LEN, DATA, WRITE and CHK.
- rst at any point returns to IDLE immediately:
  - A partial word is discarded and no write is issued.
  - Words already written remain in memory.
  - cpu_stall drops to 0.

Optional Feature:
- Macro: I_MEM_LOADER_CHECKSUM_EN.
- Defined:
  - A running XOR of all payload bytes is kept.
  - After the last WRITE the FSM enters CHK (rx_ready 1) and accepts one checksum byte.
  - Match -> DONE. Mismatch -> ERR. Words already written remain in memory.
  - With length 0, CHK still expects a byte equal to 8'h00.
- Undefined: the CHK state and XOR register are absent, and the FSM goes straight from the last WRITE (or a zero length) to DONE.

Test Plan:
- Reset: assert rst mid-cycle with random inputs -> every output immediately at its reset value; i_mem_address tracks pc.
- Two-word load with BASE_ADDR=0x100:
  - Stimulus: start; bytes 02 00 00 00 78 56 34 12 EF BE AD DE.
  - Required: single-cycle writes of 0x12345678 @0x100 and 0xDEADBEEF @0x104; load_done=1, cpu_stall=0, words_loaded=2.
- Length 00 00 00 00 -> DONE on the edge after the 4th byte; no i_mem_wr_en pulse; load_done=1.
- Length MAX_WORDS+1 -> ERR with load_err=1 and cpu_stall=1, no writes; a following start plus a valid 1-word load -> DONE with load_err cleared.
- Backpressure: one-word load with rx_valid toggled randomly and held during WRITE -> exactly 4 payload bytes consumed per word; correct data written; no byte lost or duplicated.
- Reset after 2 payload bytes of word 0 -> IDLE, no write, cpu_stall=0. With CHECKSUM_EN, a wrong checksum byte -> ERR, load_err=1.
